alu_mp_sequencer: RTL
=====================

Name: alu_mp_sequencer

Overview:
Multi-precision controller that drives the shared 8-bit ALU byte-serially to perform NBYTES-wide operations. It sequences LSB to MSB and chains the ALU carry/borrow between bytes via ADDC/SUBC. It accumulates the zero flag across all bytes and assembles the wide result. It sits between the core control unit, which issues start/op/operands, and the combinational ALU, whose a/b/fn/carryIn inputs it owns exclusively while busy.

Parameters:
NBYTES, 4, operand/result width in bytes (≥1); data width W = 8*NBYTES.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; accepted only when busy=0.
op  input  3  ALU function code: 0 ADD, 1 ADDC, 2 SUB, 3 SUBC, 4 AND, 5 OR, 6 XOR, 7 MASK.
a_in  input  W  operand A, sampled on accept.
b_in  input  W  operand B, sampled on accept.
carry_in  input  1  initial carry/borrow, sampled on accept.
busy  output  1  high from the cycle after accept through the RUN phase.
done  output  1  one-cycle pulse: result, carry_out and zero are valid.
result  output  W  assembled result; held until next accept.
carry_out  output  1  final ALU carry/borrow from the MSB byte.
zero  output  1  1 iff every byte result was zero.
alu_a  output  8  to ALU a.
alu_b  output  8  to ALU b.
alu_fn  output  3  to ALU fn.
alu_cin  output  1  to ALU carryIn.
alu_out  input  8  from ALU out.
alu_c  input  1  from ALU carry.
alu_z  input  1  from ALU zero (byte-level).

Behaviour:
- States: IDLE, RUN, DONE. Byte index idx counts 0..NBYTES-1.
- Reset (sync, any state, including mid-RUN): state=IDLE, idx=0, busy=0, done=0, result=0, carry_out=0, zero=0, internal carry reg=0, latched operands=0.
- IDLE: alu_a=0, alu_b=0, alu_fn=0, alu_cin=0. If start=1: latch a_in, b_in, op, carry_in; set idx=0; go RUN.
- RUN, byte idx:
  - alu_a = A[8*idx+:8], alu_b = B[8*idx+:8].
  - alu_fn for idx=0 is the latched op.
  - alu_fn for idx>0: ADD→ADDC, SUB→SUBC; ADDC/SUBC/logic ops unchanged.
  - alu_cin for idx=0 is the latched carry_in when op is ADDC or SUBC, else 0.
  - alu_cin for idx>0 is the registered alu_c from byte idx-1.
  - Each RUN clock: result[8*idx+:8] ← alu_out; carry reg ← alu_c; zero accumulator ← (idx==0 ? alu_z : acc & alu_z).
  - At idx=NBYTES-1: carry_out ← alu_c; go DONE. Otherwise idx+1.
- DONE: done=1 for exactly one cycle, busy=0, ALU drive returns to IDLE values. Next state is IDLE.
- Latency: start accepted at edge T. RUN covers the NBYTES cycles after T. done is high during cycle T+NBYTES+1. NBYTES=1 gives done two cycles after accept.
- start while busy=1 or in DONE is ignored (not queued). Input changes during RUN have no effect; all operands are latched.
- Logic ops (AND, OR, XOR, MASK): ALU returns carry 0, so carry_out=0 and the chain carries 0.
- Subtraction: ALU carry is the borrow (1 when a-b-cin < 0 per byte). carry_out=1 means the wide result underflowed.
- result, carry_out and zero hold their values from DONE until the next accepted start. They are partially overwritten during the following RUN and are only valid at the done pulse.
- The block contains no arithmetic itself. All data flows through the external ALU, which is combinational with same-cycle response.

Test Plan:
- NBYTES=4, ADD a=0x00FFFFFF, b=0x00000001, cin=1 (ignored for ADD) → done exactly 5 cycles after accept edge; result=0x01000000, carry_out=0, zero=0; alu_fn sequence 0,1,1,1.
- ADD 0xFFFFFFFF + 0x00000001 → result=0x00000000, carry_out=1, zero=1. ADDC 0x7FFFFFFF + 0x00000000, cin=1 → result=0x80000000, carry_out=0.
- SUB 0x00000000 − 0x00000001 → result=0xFFFFFFFF, carry_out=1, zero=0; alu_fn 2,3,3,3. SUBC 0x10000000 − 0x00000000, cin=1 → result=0x0FFFFFFF, carry_out=0.
- MASK a=0xF0F0F0F0, b=0xFF000000 → result=0x00F0F0F0, carry_out=0. XOR a=b=0x5A5A5A5A → result=0, zero=1.
- start pulsed every cycle during a RUN with different operands → only the first op completes; exactly one done pulse per accepted start; the second start is accepted only in IDLE.
- rst asserted during RUN at idx=2 → next cycle busy=0, done=0, result=0, carry_out=0, zero=0, alu_fn=0. A new start then completes normally with no stale carry.

Source files
------------

// File: rtl/alu_mp_sequencer.sv
// alu_mp_sequencer: drives a shared 8-bit combinational ALU one byte at a time,
// LSB first, to carry out an NBYTES-wide operation. The carry or borrow is
// chained between bytes, the zero flag is accumulated, and the wide result is
// assembled from the byte results.
module alu_mp_sequencer #(
    parameter int NBYTES = 4,
    localparam int W = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    input  logic         carry_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         carry_out,
    output logic         zero,
    output logic [7:0]   alu_a,
    output logic [7:0]   alu_b,
    output logic [2:0]   alu_fn,
    output logic         alu_cin,
    input  logic [7:0]   alu_out,
    input  logic         alu_c,
    input  logic         alu_z
);

    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_ADDC = 3'd1,
        OP_SUB  = 3'd2,
        OP_SUBC = 3'd3,
        OP_AND  = 3'd4,
        OP_OR   = 3'd5,
        OP_XOR  = 3'd6,
        OP_MASK = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                   state;
    logic [IW-1:0]            idx;
    logic [NBYTES-1:0][7:0]   a_q;
    logic [NBYTES-1:0][7:0]   b_q;
    logic [NBYTES-1:0][7:0]   res_q;
    logic [2:0]               op_q;
    logic                     cin_q;
    logic                     cy;

    assign result = res_q;

    // ALU drive: idle values outside RUN; during RUN, select the current byte
    // and promote ADD/SUB to their carry-chaining forms above the LSB.
    always_comb begin
        alu_a   = 8'd0;
        alu_b   = 8'd0;
        alu_fn  = 3'd0;
        alu_cin = 1'b0;
        if (state == S_RUN) begin
            alu_a = a_q[idx];
            alu_b = b_q[idx];
            if (idx == '0) begin
                alu_fn  = op_q;
                alu_cin = (op_q == OP_ADDC || op_q == OP_SUBC) ? cin_q : 1'b0;
            end else begin
                case (op_q)
                    OP_ADD:  alu_fn = OP_ADDC;
                    OP_SUB:  alu_fn = OP_SUBC;
                    default: alu_fn = op_q;
                endcase
                alu_cin = cy;
            end
        end
    end

    // Sequencer FSM: accept in IDLE, one byte per RUN cycle, one-cycle DONE pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            res_q     <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
            cy        <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= 3'd0;
            cin_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q   <= a_in;
                        b_q   <= b_in;
                        op_q  <= op;
                        cin_q <= carry_in;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    res_q[idx] <= alu_out;
                    cy         <= alu_c;
                    zero       <= (idx == '0) ? alu_z : (zero & alu_z);
                    if (idx == LAST) begin
                        carry_out <= alu_c;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                S_DONE: begin
                    // start here is dropped; the requester must retry in IDLE
                    done  <= 1'b0;
                    idx   <= '0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
